// File: rtl/force_pipeline_stream_if.sv
// Pair-in / force-out stream bundle for the force pipeline stage.
// The slave side is the pipeline. The master side is the pair filter and the accumulators.
interface force_pipeline_stream_if #(
    parameter int POS_W = 32,
    parameter int ID_W  = 17
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_done;
    logic [3*POS_W-1:0]   in_ref_pos;
    logic [ID_W-1:0]      in_ref_id;
    logic [3*POS_W-1:0]   in_nbr_pos;
    logic [ID_W-1:0]      in_nbr_id;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_done;
    logic [3*POS_W-1:0]   out_ref_force;
    logic [ID_W-1:0]      out_ref_id;
    logic [3*POS_W-1:0]   out_nbr_force;
    logic [ID_W-1:0]      out_nbr_id;
    logic [31:0]          pair_count;
    logic [31:0]          last_pairs;

    modport slave (
        input  in_valid, in_done, in_ref_pos, in_ref_id, in_nbr_pos, in_nbr_id, out_ready,
        output in_ready, out_valid, out_done, out_ref_force, out_ref_id,
               out_nbr_force, out_nbr_id, pair_count, last_pairs
    );

    modport master (
        output in_valid, in_done, in_ref_pos, in_ref_id, in_nbr_pos, in_nbr_id, out_ready,
        input  in_ready, out_valid, out_done, out_ref_force, out_ref_id,
               out_nbr_force, out_nbr_id, pair_count, last_pairs
    );
endinterface

// File: rtl/force_pipeline_stream.sv
// Streaming pair-force stage: LJ unit -> DEPTH-stage stallable pipeline.
// Outputs carry the optional reaction force and an in-band done token.
module force_lj_unit #(
    parameter int POS_W = 32
) (
    input  logic [3*POS_W-1:0] ref_pos,
    input  logic [3*POS_W-1:0] nbr_pos,
    output logic [3*POS_W-1:0] force_out
);
    // This is a bit-level stand-in for the LJ evaluator. It has the same ports and purely combinational timing.
    assign force_out = ref_pos ^ nbr_pos;
endmodule

module force_pipeline_stream #(
    parameter int POS_W         = 32,
    parameter int ID_W          = 17,
    parameter int DEPTH         = 4,
    parameter int EMIT_REACTION = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    force_pipeline_stream_if.slave bus
);
    localparam int VW = 3 * POS_W;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic [VW-1:0]   ref_force;
        logic [ID_W-1:0] ref_id;
        logic [VW-1:0]   nbr_force;
        logic [ID_W-1:0] nbr_id;
    } stage_t;

    stage_t        stage_reg  [DEPTH];
    stage_t        stage_next [DEPTH];
    stage_t        entry;
    logic          adv;
    logic          accept;
    logic          fire;
    logic [VW-1:0] lj_force;
    logic [VW-1:0] react_force;
    logic [31:0]   pair_count_reg;
    logic [31:0]   last_pairs_reg;

    force_lj_unit #(.POS_W(POS_W)) u_lj (
        .ref_pos   (bus.in_ref_pos),
        .nbr_pos   (bus.in_nbr_pos),
        .force_out (lj_force)
    );

    // Newton's third law on IEEE floats is a sign flip per component, so +0 becomes -0.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_react
            assign react_force[gi*POS_W +: POS_W] =
                {~lj_force[gi*POS_W + POS_W - 1], lj_force[gi*POS_W +: POS_W-1]};
        end
    endgenerate

    // One global enable: the whole pipe moves whenever the output slot is free or being taken.
    assign adv    = bus.out_ready | ~stage_reg[DEPTH-1].valid;
    assign accept = bus.in_valid & adv;
    assign fire   = stage_reg[DEPTH-1].valid & bus.out_ready;

    always_comb begin
        entry = '0;
        if (accept) begin
            entry.valid = 1'b1;
            entry.done  = bus.in_done;
            if (!bus.in_done) begin
                entry.ref_force = lj_force;
                entry.ref_id    = bus.in_ref_id;
                if (EMIT_REACTION != 0) begin
                    entry.nbr_force = react_force;
                    entry.nbr_id    = bus.in_nbr_id;
                end
            end
        end
    end

    assign stage_next[0] = entry;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign stage_next[gi] = stage_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
        end
    end

    // The frame counters advance only on output handshakes. This keeps them consistent with what downstream consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_count_reg <= '0;
            last_pairs_reg <= '0;
        end else if (fire) begin
            if (stage_reg[DEPTH-1].done) begin
                last_pairs_reg <= pair_count_reg;
                pair_count_reg <= '0;
            end else begin
                pair_count_reg <= pair_count_reg + 32'd1;
            end
        end
    end

    assign bus.in_ready      = adv;
    assign bus.out_valid     = stage_reg[DEPTH-1].valid;
    assign bus.out_done      = stage_reg[DEPTH-1].done;
    assign bus.out_ref_force = stage_reg[DEPTH-1].ref_force;
    assign bus.out_ref_id    = stage_reg[DEPTH-1].ref_id;
    assign bus.out_nbr_force = stage_reg[DEPTH-1].nbr_force;
    assign bus.out_nbr_id    = stage_reg[DEPTH-1].nbr_id;
    assign bus.pair_count    = pair_count_reg;
    assign bus.last_pairs    = last_pairs_reg;
endmodule

// File: tb/tb_force_pipeline_stream.sv
// Directed bench for force_pipeline_stream. The main DUT emits reaction forces.
// A second DUT has reaction forces disabled.
module tb_force_pipeline_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_done;
    logic [95:0] in_ref_pos;
    logic [16:0] in_ref_id;
    logic [95:0] in_nbr_pos;
    logic [16:0] in_nbr_id;
    logic        out_ready;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    force_pipeline_stream_if #(.POS_W(32), .ID_W(17)) bus ();
    force_pipeline_stream_if #(.POS_W(32), .ID_W(17)) bus_nr ();

    assign bus.in_valid      = in_valid;
    assign bus.in_done       = in_done;
    assign bus.in_ref_pos    = in_ref_pos;
    assign bus.in_ref_id     = in_ref_id;
    assign bus.in_nbr_pos    = in_nbr_pos;
    assign bus.in_nbr_id     = in_nbr_id;
    assign bus.out_ready     = out_ready;
    assign bus_nr.in_valid   = in_valid;
    assign bus_nr.in_done    = in_done;
    assign bus_nr.in_ref_pos = in_ref_pos;
    assign bus_nr.in_ref_id  = in_ref_id;
    assign bus_nr.in_nbr_pos = in_nbr_pos;
    assign bus_nr.in_nbr_id  = in_nbr_id;
    assign bus_nr.out_ready  = out_ready;

    force_pipeline_stream #(.POS_W(32), .ID_W(17), .DEPTH(4), .EMIT_REACTION(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    force_pipeline_stream #(.POS_W(32), .ID_W(17), .DEPTH(4), .EMIT_REACTION(0)) dut_nr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic v, input logic d, input logic [95:0] rp,
                            input logic [16:0] rid, input logic [95:0] np, input logic [16:0] nid);
        in_valid   = v;
        in_done    = d;
        in_ref_pos = rp;
        in_ref_id  = rid;
        in_nbr_pos = np;
        in_nbr_id  = nid;
    endtask

    task automatic idle;
        set_beat(1'b0, 1'b0, 96'h0, 17'h0, 96'h0, 17'h0);
    endtask

    initial begin
        logic done_pat [7];
        int   pairs_seen;
        done_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // ---- reset state
        idle();
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        check("rst_out_valid",  bus.out_valid, 1'b0);
        check("rst_out_done",   bus.out_done, 1'b0);
        check("rst_ref_force",  bus.out_ref_force, 96'h0);
        check("rst_pair_count", bus.pair_count, 32'd0);
        check("rst_last_pairs", bus.last_pairs, 32'd0);
        reset = 1'b0;
        tick();

        // ---- single pair, latency and reaction force
        set_beat(1'b1, 1'b0, {32'h3F800000, 32'h40000000, 32'h12345678}, 17'd5,
                 {32'h00000000, 32'h80000000, 32'h12345678}, 17'd9);
        #1;
        check("single_in_ready", bus.in_ready, 1'b1);
        tick();
        idle();
        tick();
        tick();
        check("single_lat_early", bus.out_valid, 1'b0);
        tick();
        check("single_lat_valid", bus.out_valid, 1'b1);
        check("single_ref_force", bus.out_ref_force, {32'h3F800000, 32'hC0000000, 32'h00000000});
        check("single_nbr_force", bus.out_nbr_force, {32'hBF800000, 32'h40000000, 32'h80000000});
        check("single_ref_id",    bus.out_ref_id, 17'd5);
        check("single_nbr_id",    bus.out_nbr_id, 17'd9);
        check("single_done",      bus.out_done, 1'b0);
        check("nr_ref_force",     bus_nr.out_ref_force, {32'h3F800000, 32'hC0000000, 32'h00000000});
        check("nr_ref_id",        bus_nr.out_ref_id, 17'd5);
        check("nr_nbr_force",     bus_nr.out_nbr_force, 96'h0);
        check("nr_nbr_id",        bus_nr.out_nbr_id, 17'd0);
        tick();
        check("single_drained",   bus.out_valid, 1'b0);
        check("single_pair_count", bus.pair_count, 32'd1);

        // ---- 8 back-to-back pairs
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 11; t++) begin
            if (t < 8)
                set_beat(1'b1, 1'b0, {64'h0, 32'(t + 1)}, 17'(t), {64'h0, 32'h100}, 17'(100 + t));
            else
                idle();
            #1;
            check($sformatf("b2b_in_ready_%0d", t), bus.in_ready, 1'b1);
            tick();
            if (t >= 3) begin
                check($sformatf("b2b_valid_%0d", t - 3), bus.out_valid, 1'b1);
                check($sformatf("b2b_ref_id_%0d", t - 3), bus.out_ref_id, 17'(t - 3));
                check($sformatf("b2b_force_%0d", t - 3), bus.out_ref_force,
                      {64'h0, 32'h100 + 32'(t - 2)});
            end else begin
                check($sformatf("b2b_fill_%0d", t), bus.out_valid, 1'b0);
            end
        end
        tick();
        check("b2b_drained",    bus.out_valid, 1'b0);
        check("b2b_pair_count", bus.pair_count, 32'd8);

        // ---- backpressure: beats 20..23 fill the pipe, and beat 24 waits
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat(1'b1, 1'b0, {64'h0, 32'hA0 + 32'(k)}, 17'(20 + k), 96'h0, 17'd0);
            tick();
        end
        set_beat(1'b1, 1'b0, {64'h0, 32'hA4}, 17'd24, 96'h0, 17'd0);
        for (int s = 0; s < 5; s++) begin
            #1;
            check($sformatf("stall_valid_%0d", s),    bus.out_valid, 1'b1);
            check($sformatf("stall_id_%0d", s),       bus.out_ref_id, 17'd20);
            check($sformatf("stall_force_%0d", s),    bus.out_ref_force, {64'h0, 32'hA0});
            check($sformatf("stall_in_ready_%0d", s), bus.in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", bus.in_ready, 1'b1);
        tick();
        idle();
        for (int k = 1; k < 5; k++) begin
            check($sformatf("stall_out_valid_%0d", 20 + k), bus.out_valid, 1'b1);
            check($sformatf("stall_out_id_%0d", 20 + k), bus.out_ref_id, 17'(20 + k));
            check($sformatf("stall_out_force_%0d", 20 + k), bus.out_ref_force, {64'h0, 32'hA0 + 32'(k)});
            tick();
        end
        check("stall_drained",    bus.out_valid, 1'b0);
        check("stall_pair_count", bus.pair_count, 32'd13);

        // ---- reset with beats in flight
        for (int k = 0; k < 3; k++) begin
            set_beat(1'b1, 1'b0, {64'h0, 32'h40 + 32'(k)}, 17'(40 + k), 96'h0, 17'd1);
            tick();
        end
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid",  bus.out_valid, 1'b0);
        check("midrst_pair_count", bus.pair_count, 32'd0);
        check("midrst_ref_id",     bus.out_ref_id, 17'd0);
        pairs_seen = 0;
        for (int s = 0; s < 6; s++) begin
            tick();
            if (bus.out_valid) pairs_seen++;
        end
        check("midrst_no_leftovers", 32'(pairs_seen), 32'd0);
        set_beat(1'b1, 1'b0, {64'h0, 32'h50}, 17'd50, 96'h0, 17'd2);
        tick();
        idle();
        tick();
        tick();
        check("midrst_new_early", bus.out_valid, 1'b0);
        tick();
        check("midrst_new_valid", bus.out_valid, 1'b1);
        check("midrst_new_id",    bus.out_ref_id, 17'd50);
        tick();
        check("midrst_new_count", bus.pair_count, 32'd1);

        // ---- done tokens: 3 pairs, done, 2 pairs, done
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (t < 7)
                set_beat(1'b1, done_pat[t], {64'hDEAD_BEEF_CAFE_F00D, 32'h60 + 32'(t)}, 17'(60 + t),
                         96'h1, 17'h1FFFF);
            else
                idle();
            tick();
            if (t >= 3) begin
                check($sformatf("done_valid_%0d", t - 3), bus.out_valid, 1'b1);
                check($sformatf("done_flag_%0d", t - 3),  bus.out_done, done_pat[t - 3]);
                if (done_pat[t - 3]) begin
                    check($sformatf("done_ref_force_%0d", t - 3), bus.out_ref_force, 96'h0);
                    check($sformatf("done_ref_id_%0d", t - 3),    bus.out_ref_id, 17'd0);
                    check($sformatf("done_nbr_force_%0d", t - 3), bus.out_nbr_force, 96'h0);
                    check($sformatf("done_nbr_id_%0d", t - 3),    bus.out_nbr_id, 17'd0);
                end else begin
                    check($sformatf("done_data_id_%0d", t - 3), bus.out_ref_id, 17'(60 + t - 3));
                end
            end
            if (t == 7) begin
                check("done1_last_pairs", bus.last_pairs, 32'd3);
                check("done1_pair_count", bus.pair_count, 32'd0);
            end
        end
        tick();
        check("done2_out_valid",  bus.out_valid, 1'b0);
        check("done2_last_pairs", bus.last_pairs, 32'd2);
        check("done2_pair_count", bus.pair_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
